// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default framing constants.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets both flops on reset so the output starts at the line's idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_sipo.sv
// 8N1-style UART receiver: mid-bit sampling, LSB-first shift, valid/ack byte handoff.
// Byte visible the cycle after the stop sample; an unacked byte is overwritten with an overrun pulse.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rxs;

  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = valid_q & ~rx_ack;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            // An ack landing on this same edge retires the old byte, so no overrun.
            dout_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~rx_ack;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign dout      = dout_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Randomized and directed frames; a scoreboard predicts each byte handoff from line timing.
module tb_uart_rx_sipo;
  localparam int C = 16;
  localparam int D = 8;
  // Cycles from driving the start bit to the stop-sample edge: 2 sync flops + 1 to see it, then mid-bit offsets.
  localparam int DONE_LAT = 3 + C / 2 + (D + 1) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic ack_rand_en = 1'b0;
  logic ack_rand    = 1'b0;
  logic ack_force   = 1'b0;
  assign rx_ack = ack_rand_en ? ack_rand : ack_force;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         done;
    logic [7:0] data;
    bit         ok;
  } exp_t;
  exp_t q[$];

  logic       mvalid = 1'b0;
  logic [7:0] mdout  = 8'h00;
  logic       mferr  = 1'b0;
  logic       movr   = 1'b0;
  logic       rst_prev = 1'b1;

  uart_rx_sipo #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 ack_rand = ($urandom % 4 == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs after edge n are compared here, then the model advances to edge n+1.
  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      chk("reset_dout", dout, 0);
      chk("reset_valid", rx_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_busy", busy, 0);
    end else begin
      chk("rx_valid", rx_valid, mvalid);
      chk("dout", dout, mdout);
      chk("frame_err", frame_err, mferr);
      chk("overrun", overrun, movr);
    end
    mferr = 1'b0;
    movr  = 1'b0;
    if (rst) begin
      mvalid = 1'b0;
      mdout  = 8'h00;
      q.delete();
    end else if (q.size() > 0 && q[0].done == cyc + 1) begin
      e = q.pop_front();
      if (e.ok) begin
        movr   = mvalid && !rx_ack;
        mvalid = 1'b1;
        mdout  = e.data;
      end else begin
        mferr = 1'b1;
        if (rx_ack) mvalid = 1'b0;
      end
    end else if (rx_ack) begin
      mvalid = 1'b0;
    end
    rst_prev = rst;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting now; a non-negative rst_bit pulses reset mid-way through that data bit.
  task automatic send(input logic [7:0] data, input bit ok, input int rst_bit);
    int s;
    s   = cyc;
    rxd = 1'b0;
    if (rst_bit < 0) q.push_back('{s + DONE_LAT, data, ok});
    wait_cyc(C);
    for (int k = 0; k < D; k++) begin
      rxd = data[k];
      if (k == rst_bit) begin
        wait_cyc(C / 2);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(C / 2 - 1);
      end else if (k == 3) begin
        wait_cyc(C / 2);
        chk("busy_mid_frame", busy, 1);
        wait_cyc(C / 2);
      end else begin
        wait_cyc(C);
      end
    end
    rxd = ok;
    wait_cyc(C);
    rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    ack_force = 1'b1;
    wait_cyc(1);
    ack_force = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    logic [7:0] d;
    bit ok;

    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);

    send(8'h55, 1'b1, -1);
    wait_cyc(4);
    ack_pulse();
    wait_cyc(2);

    fork
      send(8'hA3, 1'b1, -1);
      begin
        t = 0;
        while (!rx_valid && t < 400) begin
          wait_cyc(1);
          t++;
        end
        chk("a3_valid_seen", rx_valid, 1);
        wait_cyc(2);
        ack_pulse();
        chk("a3_valid_cleared", rx_valid, 0);
        chk("a3_dout_held", dout, 8'hA3);
      end
    join
    wait_cyc(C);

    // False start: line low for 3 cycles only.
    rxd = 1'b0;
    wait_cyc(3);
    rxd = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) n++;
    end
    @(posedge clk);
    #1;
    chk("false_start_busy_cycles", n, 8);
    chk("false_start_idle", busy, 0);

    // Bad stop bit followed by a 40-bit break.
    send(8'h3C, 1'b0, -1);
    rxd = 1'b0;
    wait_cyc(40 * C);
    chk("break_busy", busy, 1);
    rxd = 1'b1;
    wait_cyc(C);
    chk("after_break_idle", busy, 0);
    send(8'h96, 1'b1, -1);
    wait_cyc(C);

    // Back-to-back, no ack: overrun on the second frame.
    ack_pulse();
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    chk("b2b_dout", dout, 8'h22);
    chk("b2b_valid", rx_valid, 1);
    // Same again, with ack landing on the second completion edge.
    send(8'h11, 1'b1, -1);
    fork
      send(8'h22, 1'b1, -1);
      begin
        wait_cyc(DONE_LAT - 1);
        ack_pulse();
      end
    join
    wait_cyc(C);

    // Reset during data bit 4, then a clean frame.
    send(8'hF0, 1'b1, 4);
    wait_cyc(C);
    send(8'h0F, 1'b1, -1);
    wait_cyc(C);

    // Random traffic with random acks and occasional framing errors.
    ack_rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom);
      ok = ($urandom % 8) != 0;
      send(d, ok, -1);
      if (!ok) begin
        rxd = 1'b0;
        wait_cyc($urandom_range(0, 3 * C));
        rxd = 1'b1;
        wait_cyc(C);
      end else begin
        wait_cyc($urandom % 3 == 0 ? 0 : $urandom_range(1, 20));
      end
    end
    ack_rand_en = 1'b0;
    wait_cyc(200);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
